mdu: RTL and testbench

Multiply/divide unit sitting beside the 32-bit ALU in the execute stage, consuming the same A/B operands the register file delivers. It implements mult, multu, div, divu, mthi and mtlo with fixed multi-cycle latency, holds the architectural HI/LO registers, and exposes busy/stall information to the hazard unit so that dependent mfhi/mflo and new MD instructions wait.

---
 rtl/mdu.sv | 144 ++++++++++++++
 tb/tb_mdu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/multu/div/divu plus mthi/mtlo,
// holding the architectural HI/LO registers and driving stall info to hazard logic.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;       // [1] divide, [0] unsigned
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;
    logic               div_zero;
    logic               div_ovf;
    logic [63:0]        res;
    logic               res_wr;

    // Result is formed from the captured operands; only its value at cnt == 0 matters.
    always_comb begin
        prod_s   = $signed({{32{opa_q[31]}}, opa_q}) * $signed({{32{opb_q[31]}}, opb_q});
        prod_u   = {32'b0, opa_q} * {32'b0, opb_q};
        div_zero = (opb_q == 32'd0);
        div_ovf  = (opa_q == 32'h8000_0000) && (opb_q == 32'hffff_ffff);
        divisor  = div_zero ? 32'd1 : opb_q;
        quo_s    = $signed(opa_q) / $signed(divisor);
        rem_s    = $signed(opa_q) % $signed(divisor);
        if (div_ovf) begin
            quo_s = 32'sh8000_0000;
            rem_s = 32'sd0;
        end
        quo_u    = opa_q / divisor;
        rem_u    = opa_q % divisor;
        unique case (op_q)
            2'b00:   res = prod_s;
            2'b01:   res = prod_u;
            2'b10:   res = {rem_s, quo_s};
            default: res = {rem_u, quo_u};
        endcase
        res_wr   = !(op_q[1] && div_zero);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    case (md_op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            op_d    = md_op[1:0];
                            opa_d   = A;
                            opb_d   = B;
                            cnt_d   = md_op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                            busy_d  = 1'b1;
                            state_d = StRun;
                        end
                        3'b100:  hi_d = A;
                        3'b101:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (cnt_q == '0) begin
                    if (res_wr) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign stall_req = busy_q | (start & ~md_op[2]);

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases plus randomized ops
// against a 64-bit arithmetic reference model of HI/LO.
module tb_mdu;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A, B;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi, exp_lo;

    mdu #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .md_op    (md_op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .stall_req(stall_req),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operation.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] nh, output logic [31:0] nl, output logic wr);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        wr = 1'b1;
        nh = 32'd0;
        nl = 32'd0;
        case (op[1:0])
            2'b00: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
            2'b01: begin p = ua * ub; nh = p[63:32]; nl = p[31:0]; end
            2'b10: begin
                if (b == 0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
            end
            default: begin
                if (b == 0) wr = 1'b0;
                else begin p = ua / ub; nl = p[31:0]; p = ua % ub; nh = p[31:0]; end
            end
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] nh, nl;
        logic wr;
        int n;
        model(op, a, b, nh, nl, wr);
        n = op[1] ? DC : MC;
        start = 1'b1; md_op = op; A = a; B = b;
        #1 check("stall_issue", {63'b0, stall_req}, 64'd1);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            check("busy_run", {63'b0, busy}, 64'd1);
            check("done_run", {63'b0, done}, 64'd0);
            check("stall_run", {63'b0, stall_req}, 64'd1);
            check("hilo_hold", {hi, lo}, {exp_hi, exp_lo});
            // Anything issued while busy, mthi/mtlo included, must be ignored.
            start = 1'($urandom_range(0, 1));
            md_op = 3'($urandom);
            A = $urandom;
            B = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        if (wr) begin exp_hi = nh; exp_lo = nl; end
        check("busy_end", {63'b0, busy}, 64'd0);
        check("done_pulse", {63'b0, done}, 64'd1);
        check("hilo_result", {hi, lo}, {exp_hi, exp_lo});
        @(negedge clk);
        check("done_low", {63'b0, done}, 64'd0);
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        start = 1'b1; md_op = op; A = a; B = $urandom;
        #1 check("stall_mt", {63'b0, stall_req}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        if (op == 3'b100) exp_hi = a;
        if (op == 3'b101) exp_lo = a;
        check("hilo_mt", {hi, lo}, {exp_hi, exp_lo});
        check("busy_mt", {62'b0, busy, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        rst_n = 1'b0; start = 1'b0; md_op = '0; A = '0; B = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {29'b0, busy, done, stall_req, hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset clears HI/LO with no clock edge.
        run_mt(3'b100, 32'h1234_5678);
        run_mt(3'b101, 32'h9abc_def0);
        rst_n = 1'b0;
        #1 check("async_reset", {30'b0, busy, done, hi, lo}, 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_md(3'b000, 32'hffff_fffe, 32'd3);
        check("mult_dir", {hi, lo}, 64'hffff_ffff_ffff_fffa);
        run_md(3'b001, 32'hffff_fffe, 32'd3);
        check("multu_dir", {hi, lo}, 64'h0000_0002_ffff_fffa);
        run_md(3'b010, 32'hffff_fff9, 32'd2);
        check("div_dir", {hi, lo}, 64'hffff_ffff_ffff_fffd);
        run_md(3'b011, 32'd7, 32'd2);
        check("divu_dir", {hi, lo}, 64'h0000_0001_0000_0003);
        run_md(3'b010, 32'h8000_0000, 32'hffff_ffff);
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

        run_mt(3'b100, 32'h11);
        run_mt(3'b101, 32'h22);
        run_md(3'b010, 32'h1234, 32'd0);
        check("div_zero", {hi, lo}, 64'h0000_0011_0000_0022);
        run_md(3'b011, 32'h1234, 32'd0);
        check("divu_zero", {hi, lo}, 64'h0000_0011_0000_0022);
        run_mt(3'b110, 32'hdead);
        run_mt(3'b111, 32'hbeef);

        // Reset in the middle of a divide discards it.
        start = 1'b1; md_op = 3'b010; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_mid_div", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        #1 check("reset_mid_div", {30'b0, busy, done, hi, lo}, 64'd0);
        exp_hi = '0; exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DC + 2; i++) begin
            @(negedge clk);
            check("no_done_after_rst", {62'b0, busy, done}, 64'd0);
        end
        run_md(3'b000, 32'd6, 32'd7);
        check("mult_after_rst", {hi, lo}, 64'd42);

        for (int t = 0; t < 80; t++) begin
            rop = 3'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hffff_ffff;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hffff_ffff;
                2: rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            if (rop[2]) run_mt(rop, ra);
            else run_md(rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
